// File: rtl/mtr_drv_if.sv
// Motor-driver bus: signed wheel speeds in, complementary H-bridge drives and period marker out.
interface mtr_drv_if;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lftPWM1;
    logic               lftPWM2;
    logic               rghtPWM1;
    logic               rghtPWM2;
    logic               pwm_synch;

    modport master (
        output lft_spd, rght_spd,
        input  lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_synch
    );

    modport slave (
        input  lft_spd, rght_spd,
        output lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_synch
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: speeds sampled once per 2048-clock period, complementary outputs with dead time.
// Optional macro SLEW_LIMIT_EN limits the duty change per period to SLEW_STEP.
module mtr_drv #(
    parameter int DEAD_CYC = 32
`ifdef SLEW_LIMIT_EN
    , parameter int SLEW_STEP = 64
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    mtr_drv_if.slave   bus
);

    localparam logic [5:0] DEAD6 = 6'(DEAD_CYC);

    logic [10:0] cnt;
    logic        ld;
    logic [10:0] spd [2];
    logic [1:0]  pwm1;
    logic [1:0]  pwm2;

    assign ld  = (cnt == 11'h7FF);
    assign spd[0] = bus.lft_spd;
    assign spd[1] = bus.rght_spd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 11'd0;
        else        cnt <= cnt + 11'd1;
    end

    for (genvar s = 0; s < 2; s++) begin : g_ch
        logic [10:0] duty;
        logic [10:0] tgt;
        logic [10:0] duty_nxt;
        logic        raw;
        logic        raw_d;
        logic        raw_edge;
        logic [5:0]  dead;
        logic [5:0]  dead_nxt;
        logic        gate;
        logic        p1;
        logic        p2;

        // Adding 0x400 modulo 2048 is an MSB flip: signed speed to offset-binary duty.
        assign tgt = spd[s] ^ 11'h400;

`ifdef SLEW_LIMIT_EN
        localparam logic [11:0] STEP12 = 12'(SLEW_STEP);
        logic [11:0] t12;
        logic [11:0] d12;
        logic [11:0] up12;
        logic [11:0] dn12;

        assign t12  = {1'b0, tgt};
        assign d12  = {1'b0, duty};
        assign up12 = d12 + STEP12;
        assign dn12 = d12 - STEP12;

        always_comb begin
            duty_nxt = tgt;
            if (t12 > up12)
                duty_nxt = up12[10:0];
            else if ((d12 > STEP12) && (t12 < dn12))
                duty_nxt = dn12[10:0];
        end
`else
        assign duty_nxt = tgt;
`endif

        assign raw      = (cnt < duty);
        assign raw_edge = raw ^ raw_d;
        assign dead_nxt = raw_edge        ? 6'd0 :
                          (dead == DEAD6) ? dead : dead + 6'd1;
        // Gate on the post-update count so the edge cycle itself is already blanked.
        assign gate     = (dead_nxt == DEAD6);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty  <= 11'h400;
                raw_d <= 1'b0;
                dead  <= 6'd0;
                p1    <= 1'b0;
                p2    <= 1'b0;
            end else begin
                if (ld) duty <= duty_nxt;
                raw_d <= raw;
                dead  <= dead_nxt;
                p1    <= raw & gate;
                p2    <= ~raw & gate;
            end
        end

        assign pwm1[s] = p1;
        assign pwm2[s] = p2;
    end

    assign bus.lftPWM1   = pwm1[0];
    assign bus.lftPWM2   = pwm2[0];
    assign bus.rghtPWM1  = pwm1[1];
    assign bus.rghtPWM2  = pwm2[1];
    assign bus.pwm_synch = ld;

endmodule
